// File: rtl/tile_pkg.sv
// ----------------------------------------------------------------------------
// tile_pkg
// Shared constants and types for the 4x4 output-stationary systolic tile
// and its operand feeder.
//   N, DW, K, PE_LAT : array size, element width, reduction depth, PE latency
//   FEED_LEN         : cycles spent streaming skewed operands (K+N-1)
//   FLUSH_LEN        : cycles of zero feed that drain the last products
//   T_W, BEAT_W      : widths of the phase counter and the beat counter
//   feeder_state_t   : feeder FSM states
//   operand_t        : one matrix element
// ----------------------------------------------------------------------------
package tile_pkg;

   localparam int N      = 4;
   localparam int DW     = 8;
   localparam int K      = 4;
   localparam int PE_LAT = 1;

   localparam int FEED_LEN  = K + N - 1;
   localparam int FLUSH_LEN = N - 1 + PE_LAT;

   // The phase counter is shared by FEED and FLUSH, so size it for the longer one.
   localparam int T_MAX  = (FEED_LEN > FLUSH_LEN) ? FEED_LEN : FLUSH_LEN;
   localparam int T_W    = $clog2(T_MAX + 1);
   localparam int BEAT_W = (K > 1) ? $clog2(K) : 1;

   typedef logic [DW-1:0] operand_t;

   typedef enum logic [2:0] {
      LOAD,
      CLEAR,
      FEED,
      FLUSH,
      DONE
   } feeder_state_t;

endpackage

// File: rtl/tile_feeder_skew_select.sv
// ----------------------------------------------------------------------------
// skew_select
// Picks the element a single row/column lane must present at feed time t.
// Lane LANE is delayed LANE cycles, so it shows element k when t == k+LANE
// and zero for every other t.
//   elems_i : the K elements of this lane, element k at [k*DW +: DW]
//   t_i     : feed time being prepared
//   elem_o  : selected element, or zero outside the lane's window
// ----------------------------------------------------------------------------
module skew_select
   import tile_pkg::*;
#(
   parameter int LANE = 0
) (
   input  logic [K*DW-1:0] elems_i,
   input  logic [T_W-1:0]  t_i,
   output operand_t        elem_o
);

   // Zero is the default so the pad region never carries a stale element;
   // at most one k can match because t is compared against distinct offsets.
   always_comb begin
      elem_o = '0;
      for (int k = 0; k < K; k++) begin
         if (t_i == T_W'(k + LANE)) begin
            elem_o = elems_i[k*DW +: DW];
         end
      end
   end

endmodule

// File: rtl/tile_feeder.sv
// ----------------------------------------------------------------------------
// tile_feeder
// Operand producer for the 4x4 output-stationary systolic tile. Collects K
// beats (one column of A plus one row of B per beat), then clears the tile
// accumulators, streams the operands with diagonal skew, flushes zeros until
// the last product lands in PE(N-1,N-1), and pulses done.
//   clk, reset       : clock, synchronous active-high reset
//   in_valid/ready   : operand beat handshake (ready only in LOAD)
//   in_a, in_b       : A[i][k] at [i*DW +: DW], B[k][j] at [j*DW +: DW]
//   row_a, col_b     : skewed, zero-padded tile edge inputs (registered)
//   feed_en, acc_clr : tile enable and one-cycle accumulator clear
//   done             : one-cycle pulse, tile y outputs valid this cycle
//   busy             : high in every state except LOAD
// ----------------------------------------------------------------------------
module tile_feeder
   import tile_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [N*DW-1:0] in_a,
   input  logic [N*DW-1:0] in_b,
   output logic [N*DW-1:0] row_a,
   output logic [N*DW-1:0] col_b,
   output logic          feed_en,
   output logic          acc_clr,
   output logic          done,
   output logic          busy
);

   feeder_state_t    state_q;
   logic [BEAT_W-1:0] beatCnt_q;
   logic [T_W-1:0]   tCnt_q;
   logic [T_W-1:0]   feedT_d;

   logic [N*DW-1:0]  aBuf_q [K];
   logic [N*DW-1:0]  bBuf_q [K];

   logic             inReady_q;
   logic [N*DW-1:0]  rowA_q;
   logic [N*DW-1:0]  colB_q;
   logic             feedEn_q;
   logic             accClr_q;
   logic             done_q;
   logic             busy_q;

   logic [K*DW-1:0]  rowElems [N];
   logic [K*DW-1:0]  colElems [N];
   logic [N*DW-1:0]  rowSel;
   logic [N*DW-1:0]  colSel;

   assign in_ready = inReady_q;
   assign row_a    = rowA_q;
   assign col_b    = colB_q;
   assign feed_en  = feedEn_q;
   assign acc_clr  = accClr_q;
   assign done     = done_q;
   assign busy     = busy_q;

   // Outputs are registered, so the lanes are prepared one cycle ahead:
   // CLEAR prepares t=0, and each FEED cycle t prepares t+1.
   always_comb begin
      feedT_d = '0;
      if (state_q == FEED) begin
         feedT_d = tCnt_q + T_W'(1);
      end
   end

   // Regroup the beat-major buffer into per-lane vectors: row i needs
   // A[i][0..K-1] and column j needs B[0..K-1][j].
   always_comb begin
      for (int g = 0; g < N; g++) begin
         rowElems[g] = '0;
         colElems[g] = '0;
         for (int k = 0; k < K; k++) begin
            rowElems[g][k*DW +: DW] = aBuf_q[k][g*DW +: DW];
            colElems[g][k*DW +: DW] = bBuf_q[k][g*DW +: DW];
         end
      end
   end

   for (genvar g = 0; g < N; g++) begin : gLane
      skew_select #(.LANE(g)) uRowSel (
         .elems_i (rowElems[g]),
         .t_i     (feedT_d),
         .elem_o  (rowSel[g*DW +: DW])
      );
      skew_select #(.LANE(g)) uColSel (
         .elems_i (colElems[g]),
         .t_i     (feedT_d),
         .elem_o  (colSel[g*DW +: DW])
      );
   end

   // Feeder FSM. Every output is set on the edge that enters the state it
   // belongs to. The buffer is only written on accepted beats in LOAD, which
   // keeps it stable for the whole FEED phase; reset leaves it untouched
   // because a fresh load always overwrites every slot before use.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= LOAD;
         beatCnt_q <= '0;
         tCnt_q    <= '0;
         inReady_q <= 1'b1;
         rowA_q    <= '0;
         colB_q    <= '0;
         feedEn_q  <= 1'b0;
         accClr_q  <= 1'b0;
         done_q    <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            LOAD: begin
               if (in_valid && inReady_q) begin
                  aBuf_q[beatCnt_q] <= in_a;
                  bBuf_q[beatCnt_q] <= in_b;
                  if (beatCnt_q == BEAT_W'(K - 1)) begin
                     beatCnt_q <= '0;
                     state_q   <= CLEAR;
                     inReady_q <= 1'b0;
                     accClr_q  <= 1'b1;
                     busy_q    <= 1'b1;
                  end else begin
                     beatCnt_q <= beatCnt_q + BEAT_W'(1);
                  end
               end
            end
            CLEAR: begin
               accClr_q <= 1'b0;
               feedEn_q <= 1'b1;
               tCnt_q   <= '0;
               rowA_q   <= rowSel;
               colB_q   <= colSel;
               state_q  <= FEED;
            end
            FEED: begin
               if (tCnt_q == T_W'(FEED_LEN - 1)) begin
                  tCnt_q  <= '0;
                  rowA_q  <= '0;
                  colB_q  <= '0;
                  state_q <= FLUSH;
               end else begin
                  tCnt_q <= tCnt_q + T_W'(1);
                  rowA_q <= rowSel;
                  colB_q <= colSel;
               end
            end
            FLUSH: begin
               if (tCnt_q == T_W'(FLUSH_LEN - 1)) begin
                  tCnt_q   <= '0;
                  feedEn_q <= 1'b0;
                  done_q   <= 1'b1;
                  state_q  <= DONE;
               end else begin
                  tCnt_q <= tCnt_q + T_W'(1);
               end
            end
            DONE: begin
               done_q    <= 1'b0;
               inReady_q <= 1'b1;
               busy_q    <= 1'b0;
               state_q   <= LOAD;
            end
            default: begin
               state_q <= LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_tile_feeder.sv
// ----------------------------------------------------------------------------
// tb_tile_feeder
// Directed bench for tile_feeder. A small behavioural 4x4 output-stationary
// tile sits on the feeder outputs so whole-operation results can be checked.
// ----------------------------------------------------------------------------
module tb_tile_feeder;
   import tile_pkg::*;

   logic            clk = 1'b0;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [N*DW-1:0] in_a;
   logic [N*DW-1:0] in_b;
   logic [N*DW-1:0] row_a;
   logic [N*DW-1:0] col_b;
   logic            feed_en;
   logic            acc_clr;
   logic            done;
   logic            busy;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   tile_feeder dut (
      .clk      (clk),
      .reset    (reset),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_a     (in_a),
      .in_b     (in_b),
      .row_a    (row_a),
      .col_b    (col_b),
      .feed_en  (feed_en),
      .acc_clr  (acc_clr),
      .done     (done),
      .busy     (busy)
   );

   // Behavioural tile: a flows right, b flows down, each PE accumulates a*b.
   logic [DW-1:0] aR  [N][N];
   logic [DW-1:0] bR  [N][N];
   logic [DW-1:0] aIn [N][N];
   logic [DW-1:0] bIn [N][N];
   logic [31:0]   acc [N][N];

   // PE input wiring: edge lanes from the feeder, inner PEs from neighbours.
   always_comb begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            aIn[i][j] = '0;
            bIn[i][j] = '0;
         end
      end
      for (int i = 0; i < N; i++) begin
         aIn[i][0] = row_a[i*DW +: DW];
         for (int j = 1; j < N; j++) aIn[i][j] = aR[i][j-1];
      end
      for (int j = 0; j < N; j++) begin
         bIn[0][j] = col_b[j*DW +: DW];
         for (int i = 1; i < N; i++) bIn[i][j] = bR[i-1][j];
      end
   end

   // Tile state update: clear wins over feed.
   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            if (acc_clr) begin
               acc[i][j] <= '0;
               aR[i][j]  <= '0;
               bR[i][j]  <= '0;
            end else if (feed_en) begin
               acc[i][j] <= acc[i][j] + 32'(aIn[i][j]) * 32'(bIn[i][j]);
               aR[i][j]  <= aIn[i][j];
               bR[i][j]  <= bIn[i][j];
            end
         end
      end
   end

   // Operand sets: 0 A=1,B=2 | 1 A=16i+k,B=16k+j | 2 A=I,B=k+j | 3 A=k+1,B=1 | 4 A=3,B=1
   function automatic logic [N*DW-1:0] beatA(input int mode, input int k);
      logic [N*DW-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++) begin
         case (mode)
            0:       v[i*DW +: DW] = DW'(1);
            1:       v[i*DW +: DW] = DW'(16*i + k);
            2:       v[i*DW +: DW] = DW'((i == k) ? 1 : 0);
            3:       v[i*DW +: DW] = DW'(k + 1);
            4:       v[i*DW +: DW] = DW'(3);
            default: v[i*DW +: DW] = DW'(8'hFF);
         endcase
      end
      return v;
   endfunction

   function automatic logic [N*DW-1:0] beatB(input int mode, input int k);
      logic [N*DW-1:0] v;
      v = '0;
      for (int j = 0; j < N; j++) begin
         case (mode)
            0:       v[j*DW +: DW] = DW'(2);
            1:       v[j*DW +: DW] = DW'(16*k + j);
            2:       v[j*DW +: DW] = DW'(k + j);
            3:       v[j*DW +: DW] = DW'(1);
            4:       v[j*DW +: DW] = DW'(1);
            default: v[j*DW +: DW] = DW'(8'hFF);
         endcase
      end
      return v;
   endfunction

   // Hand-computed C = A*B for the operand sets above.
   function automatic logic [31:0] expY(input int mode, input int i, input int j);
      case (mode)
         0:       return 32'd8;
         2:       return 32'(i + j);
         3:       return 32'd10;
         4:       return 32'd12;
         default: return 32'd0;
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Present one beat from a negedge and hold it until accepted; returns at
   // the negedge after the accepting edge with the number of stalled cycles.
   task automatic applyStimulus(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b,
                                output int waited);
      in_a     = a;
      in_b     = b;
      in_valid = 1'b1;
      waited   = 0;
      while (!in_ready && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      if (in_ready) begin
         @(posedge clk);
         @(negedge clk);
      end else begin
         checkOutput("beat_accept_timeout", {31'b0, in_ready}, 32'd1);
      end
   endtask

   task automatic loadOp(input int mode, output int firstWait);
      int w;
      firstWait = 0;
      for (int k = 0; k < K; k++) begin
         applyStimulus(beatA(mode, k), beatB(mode, k), w);
         if (k == 0) firstWait = w;
      end
      in_valid = 1'b0;
   endtask

   // Called at the negedge just after the last accepted beat (cycle E+1).
   task automatic waitDone(output int off);
      off = 1;
      while (!done && off < 60) begin
         @(negedge clk);
         off++;
      end
   endtask

   task automatic checkY(input string tag, input int mode);
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
            checkOutput($sformatf("%s_y%0d%0d", tag, i, j), acc[i][j], expY(mode, i, j));
         end
      end
   endtask

   initial begin
      #50000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int w;
      int off;
      int beat;
      int leaked;
      int doneCnt;
      logic [6:0] pat;

      reset    = 1'b1;
      in_valid = 1'b0;
      in_a     = '0;
      in_b     = '0;
      repeat (2) @(negedge clk);

      // Reset state
      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_busy",     busy,     0);
      checkOutput("rst_feed_en",  feed_en,  0);
      checkOutput("rst_acc_clr",  acc_clr,  0);
      checkOutput("rst_done",     done,     0);
      checkOutput("rst_row_a",    row_a,    0);
      checkOutput("rst_col_b",    col_b,    0);
      reset = 1'b0;

      // Operation 1: A all 1, B all 2
      loadOp(0, w);
      checkOutput("op1_acc_clr",  acc_clr,  1);
      checkOutput("op1_in_ready", in_ready, 0);
      checkOutput("op1_busy",     busy,     1);
      checkOutput("op1_feed_en",  feed_en,  0);
      waitDone(off);
      checkOutput("op1_done_cycle", off,     13);
      checkOutput("op1_done",       done,    1);
      checkOutput("op1_done_feed",  feed_en, 0);
      checkY("op1", 0);

      // Back-to-back: first beat presented in the cycle after done
      @(negedge clk);
      checkOutput("b2b_in_ready", in_ready, 1);
      checkOutput("b2b_done_low", done,     0);
      checkOutput("b2b_busy",     busy,     0);
      loadOp(2, w);
      checkOutput("b2b_first_wait", w, 0);
      waitDone(off);
      checkOutput("op2_done_cycle", off, 13);
      checkY("op2", 2);

      // Skew and zero padding
      @(negedge clk);
      loadOp(1, w);
      checkOutput("skew_acc_clr", acc_clr, 1);
      @(negedge clk);
      checkOutput("skew_t0_feed_en", feed_en, 1);
      checkOutput("skew_t0_acc_clr", acc_clr, 0);
      checkOutput("skew_t0_row", row_a, 32'h0000_0000);
      checkOutput("skew_t0_col", col_b, 32'h0000_0000);
      @(negedge clk);
      checkOutput("skew_t1_row", row_a, 32'h0000_1001);
      checkOutput("skew_t1_col", col_b, 32'h0000_0110);
      @(negedge clk);
      checkOutput("skew_t2_row", row_a, 32'h0020_1102);
      checkOutput("skew_t2_col", col_b, 32'h0002_1120);
      @(negedge clk);
      checkOutput("skew_t3_row", row_a, 32'h3021_1203);
      checkOutput("skew_t3_col", col_b, 32'h0312_2130);
      repeat (3) @(negedge clk);
      checkOutput("skew_t6_row", row_a, 32'h3300_0000);
      checkOutput("skew_t6_col", col_b, 32'h3300_0000);
      for (int f = 0; f < FLUSH_LEN; f++) begin
         @(negedge clk);
         checkOutput($sformatf("flush%0d_row", f),  row_a,   0);
         checkOutput($sformatf("flush%0d_col", f),  col_b,   0);
         checkOutput($sformatf("flush%0d_feed", f), feed_en, 1);
      end
      @(negedge clk);
      checkOutput("skew_done",      done,    1);
      checkOutput("skew_done_feed", feed_en, 0);
      checkOutput("skew_y00", acc[0][0], 32'd224);
      checkOutput("skew_y33", acc[3][3], 32'd5426);

      // Backpressure: valid pattern 1,0,0,1,0,1,1
      @(negedge clk);
      pat  = 7'b1101001;
      beat = 0;
      for (int c = 0; c < 7; c++) begin
         in_valid = pat[c];
         in_a     = beatA(3, beat);
         in_b     = beatB(3, beat);
         checkOutput($sformatf("bp_c%0d_in_ready", c), in_ready, 1);
         @(posedge clk);
         @(negedge clk);
         if (pat[c]) beat++;
         checkOutput($sformatf("bp_c%0d_acc_clr", c), acc_clr, (c == 6) ? 1 : 0);
      end
      // Keep offering a junk beat throughout the operation
      in_a   = {N{8'hFF}};
      in_b   = {N{8'hFF}};
      leaked = 0;
      off    = 1;
      while (!done && off < 60) begin
         if (in_ready) leaked++;
         @(negedge clk);
         off++;
      end
      in_valid = 1'b0;
      checkOutput("bp_ready_leak", leaked, 0);
      checkOutput("bp_done_cycle", off,    13);
      checkY("bp", 3);

      // Reset during FEED t=2
      @(negedge clk);
      loadOp(0, w);
      repeat (3) @(negedge clk);
      checkOutput("mid_feed_en", feed_en, 1);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("mid_rst_in_ready", in_ready, 1);
      checkOutput("mid_rst_feed_en",  feed_en,  0);
      checkOutput("mid_rst_acc_clr",  acc_clr,  0);
      checkOutput("mid_rst_row",      row_a,    0);
      checkOutput("mid_rst_col",      col_b,    0);
      checkOutput("mid_rst_busy",     busy,     0);
      reset   = 1'b0;
      doneCnt = 0;
      for (int c = 0; c < 15; c++) begin
         if (done) doneCnt++;
         @(negedge clk);
      end
      checkOutput("mid_rst_no_done",  doneCnt,  0);
      checkOutput("mid_rst_idle_rdy", in_ready, 1);

      // Partial load discarded by reset
      applyStimulus({N{8'hFF}}, {N{8'hFF}}, w);
      applyStimulus({N{8'hFF}}, {N{8'hFF}}, w);
      in_valid = 1'b0;
      checkOutput("partial_acc_clr", acc_clr, 0);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;

      // Full load after the resets
      loadOp(4, w);
      checkOutput("post_rst_acc_clr", acc_clr, 1);
      waitDone(off);
      checkOutput("post_rst_done_cycle", off, 13);
      checkY("post_rst", 4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
